// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared MIPS pipeline constants and fetch entry layout
package mips_pipe_pkg;

    localparam int          DEF_INST_W   = 32;
    localparam int          DEF_ADDR_W   = 32;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST     = 32'h0000_0000;

    // One buffered fetch: instruction word, its PC and PC+4 (MSB first).
    typedef struct packed {
        logic [DEF_INST_W-1:0] data;
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_ADDR_W-1:0] pc4;
    } fetch_entry_t;

    // Packed width of a fetch entry for arbitrary instruction/address widths.
    function automatic int fetch_entry_w(input int inst_w, input int addr_w);
        return inst_w + 2 * addr_w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with flush and occupancy count
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   i_push       write i_push_data at the tail
//   i_push_data  entry to write
//   i_pop        retire the head entry
//   i_flush      empty the FIFO (wins over push/pop)
//   o_head_data  head entry, read straight from storage
//   o_count      number of valid entries (0..DEPTH)
module sync_fifo #(
    parameter int               DEPTH   = 4,
    parameter int               WIDTH   = 96,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [WIDTH-1:0]           o_head_data,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RST_VAL;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    assign o_head_data = r_mem[r_rd_ptr];
    assign o_count     = r_count;

endmodule

// File: rtl/if_prefetch_queue.sv
// rtl/if_prefetch_queue.sv - in-order instruction prefetch queue feeding IF/ID
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   imem_req_valid/ready/addr    fetch request channel to instruction memory
//   imem_rsp_valid/data          in-order response words from instruction memory
//   stall                        hold the head entry (no dequeue)
//   redirect_valid/pc            taken branch/jump: flush and refetch from redirect_pc
//   inst_valid/data/pc/pc4       head entry presented to IF/ID
module if_prefetch_queue
    import mips_pipe_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DATA_W   = DEF_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] inst_pc4
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = fetch_entry_w(DATA_W, ADDR_W);
    localparam logic [ENTRY_W-1:0] ENTRY_RST = {DATA_W'(NOP_INST), {(2*ADDR_W){1'b0}}};

    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_rsp_pc;
    logic [CNT_W-1:0]   r_outstanding;
    logic [CNT_W-1:0]   r_drop_cnt;

    logic [CNT_W-1:0]   w_count;
    logic [ENTRY_W-1:0] w_head;
    logic [CNT_W:0]     w_credit_used;
    logic               w_req_fire;
    logic               w_rsp_ok;
    logic               w_drop;
    logic               w_push;
    logic               w_pop;
    logic [CNT_W-1:0]   w_out_next;

    // Buffered plus in-flight fetches may never exceed DEPTH, so every
    // response is guaranteed a free slot when it lands.
    assign w_credit_used  = (CNT_W+1)'(w_count) + (CNT_W+1)'(r_outstanding);
    assign imem_req_valid = !rst && !redirect_valid && (w_credit_used < (CNT_W+1)'(DEPTH));
    assign imem_addr      = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign w_rsp_ok   = imem_rsp_valid && (r_outstanding != '0);
    assign w_drop     = w_rsp_ok && (r_drop_cnt != '0);
    assign w_push     = w_rsp_ok && !w_drop && !redirect_valid;
    assign w_pop      = inst_valid && !stall && !redirect_valid;
    assign w_out_next = r_outstanding + CNT_W'(w_req_fire) - CNT_W'(w_rsp_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (redirect_valid) begin
                // Everything still in flight after this cycle belongs to the
                // old stream and must be discarded on arrival.
                r_fetch_pc <= redirect_pc;
                r_rsp_pc   <= redirect_pc;
                r_drop_cnt <= w_out_next;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + ADDR_W'(4);
                end
                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt - CNT_W'(1);
                end
            end
        end
    end

    sync_fifo #(
        .DEPTH   (DEPTH),
        .WIDTH   (ENTRY_W),
        .RST_VAL (ENTRY_RST)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data ({imem_rsp_data, r_rsp_pc, r_rsp_pc + ADDR_W'(4)}),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_head_data (w_head),
        .o_count     (w_count)
    );

    assign inst_valid = (w_count != '0);
    assign inst_data  = w_head[ENTRY_W-1 -: DATA_W];
    assign inst_pc    = w_head[2*ADDR_W-1 -: ADDR_W];
    assign inst_pc4   = w_head[ADDR_W-1:0];

    a_outstanding_max: assert property (@(posedge clk) disable iff (rst) r_outstanding <= CNT_W'(DEPTH));
    a_count_max:       assert property (@(posedge clk) disable iff (rst) w_count <= CNT_W'(DEPTH));
    a_drop_max:        assert property (@(posedge clk) disable iff (rst) r_drop_cnt <= CNT_W'(DEPTH));
    a_rsp_protocol:    assert property (@(posedge clk) disable iff (rst) !(imem_rsp_valid && r_outstanding == '0));

endmodule

// File: tb/tb_if_prefetch_queue.sv
// tb/tb_if_prefetch_queue.sv - directed self-checking bench for if_prefetch_queue
module tb_if_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t pq[$];
    int    cyc;
    int    lat;

    logic        s_req_valid;
    logic [31:0] s_addr;
    logic        s_iv;
    logic [31:0] s_data;
    logic [31:0] s_pc;
    logic [31:0] s_pc4;

    if_prefetch_queue #(
        .DEPTH    (4),
        .ADDR_W   (32),
        .DATA_W   (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_pc4       (inst_pc4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    // One clock cycle: present the memory response, sample outputs, take the edge,
    // then update the in-order memory model. Called at the falling edge.
    task automatic tick();
        if (pq.size() != 0 && pq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
        s_req_valid = imem_req_valid;
        s_addr      = imem_addr;
        s_iv        = inst_valid;
        s_data      = inst_data;
        s_pc        = inst_pc;
        s_pc4       = inst_pc4;
        @(posedge clk);
        if (s_req_valid && imem_req_ready) pq.push_back('{s_addr, cyc + lat});
        if (imem_rsp_valid) pq.delete(0);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        pq.delete();
        cyc = 0;
        lat = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
        checks++;
        if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_inst_valid got=%b exp=0", inst_valid); end
        checks++;
        if (inst_data !== 32'h0 || inst_pc !== 32'h0 || inst_pc4 !== 32'h0) begin
            failures++; $display("FAIL reset_inst_fields got=%h/%h/%h exp=0/0/0", inst_data, inst_pc, inst_pc4);
        end
        checks++;
        if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (s_req_valid !== 1'b1 || s_addr !== 32'(4*c)) begin
                failures++; $display("FAIL stream_req c=%0d got=%b/%h exp=1/%h", c, s_req_valid, s_addr, 32'(4*c));
            end
            checks++;
            if (c < 2) begin
                if (s_iv !== 1'b0) begin failures++; $display("FAIL stream_early_valid c=%0d got=%b exp=0", c, s_iv); end
            end else if (s_iv !== 1'b1 || s_pc !== 32'(4*(c-2)) || s_pc4 !== 32'(4*(c-1)) || s_data !== mem_word(32'(4*(c-2)))) begin
                failures++; $display("FAIL stream_head c=%0d got=%b/%h/%h/%h exp=1/%h/%h/%h", c, s_iv, s_pc, s_pc4, s_data,
                                     32'(4*(c-2)), 32'(4*(c-1)), mem_word(32'(4*(c-2))));
            end
        end
    endtask

    task automatic test_stall();
        logic exp_req [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        repeat (4) tick();
        stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (s_iv !== 1'b1 || s_pc !== 32'h8 || s_data !== mem_word(32'h8)) begin
                failures++; $display("FAIL stall_hold i=%0d got=%b/%h/%h exp=1/00000008/%h", i, s_iv, s_pc, s_data, mem_word(32'h8));
            end
            checks++;
            if (s_req_valid !== exp_req[i] || (exp_req[i] && s_addr !== 32'(16 + 4*i))) begin
                failures++; $display("FAIL stall_credit i=%0d got=%b/%h exp=%b/%h", i, s_req_valid, s_addr, exp_req[i], 32'(16 + 4*i));
            end
        end
        stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (s_iv !== 1'b1 || s_pc !== 32'(8 + 4*i) || s_pc4 !== 32'(12 + 4*i)) begin
                failures++; $display("FAIL stall_drain i=%0d got=%b/%h/%h exp=1/%h/%h", i, s_iv, s_pc, s_pc4, 32'(8 + 4*i), 32'(12 + 4*i));
            end
            if (i == 0) begin
                checks++;
                if (s_req_valid !== 1'b0) begin failures++; $display("FAIL stall_full_pop_req got=%b exp=0", s_req_valid); end
            end
        end
    endtask

    task automatic test_redirect_drop();
        do_reset();
        lat = 3;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (s_iv !== 1'b0) begin failures++; $display("FAIL drop_pre_valid c=%0d got=%b exp=0", c, s_iv); end
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        checks++;
        if (s_req_valid !== 1'b0) begin failures++; $display("FAIL drop_redirect_req got=%b exp=0", s_req_valid); end
        redirect_valid = 1'b0;
        for (int c = 4; c < 8; c++) begin
            tick();
            checks++;
            if (s_iv !== 1'b0) begin failures++; $display("FAIL drop_stale_valid c=%0d got=%b/%h exp=0", c, s_iv, s_pc); end
            if (c == 4) begin
                checks++;
                if (s_req_valid !== 1'b1 || s_addr !== 32'h100) begin
                    failures++; $display("FAIL drop_first_req got=%b/%h exp=1/00000100", s_req_valid, s_addr);
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (s_iv !== 1'b1 || s_pc !== 32'(32'h100 + 4*i) || s_data !== mem_word(32'(32'h100 + 4*i))) begin
                failures++; $display("FAIL drop_new_head i=%0d got=%b/%h/%h exp=1/%h/%h", i, s_iv, s_pc, s_data,
                                     32'(32'h100 + 4*i), mem_word(32'(32'h100 + 4*i)));
            end
        end
    endtask

    task automatic test_redirect_collide();
        do_reset();
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick();
        checks++;
        if (s_iv !== 1'b1 || s_pc !== 32'h4 || imem_rsp_valid !== 1'b1) begin
            failures++; $display("FAIL collide_setup got=%b/%h/%b exp=1/00000004/1", s_iv, s_pc, imem_rsp_valid);
        end
        redirect_valid = 1'b0;
        tick();
        checks++;
        if (s_iv !== 1'b0 || s_req_valid !== 1'b1 || s_addr !== 32'h200) begin
            failures++; $display("FAIL collide_flush got=%b/%b/%h exp=0/1/00000200", s_iv, s_req_valid, s_addr);
        end
        tick();
        checks++;
        if (s_iv !== 1'b0) begin failures++; $display("FAIL collide_gap got=%b exp=0", s_iv); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (s_iv !== 1'b1 || s_pc !== 32'(32'h200 + 4*i) || s_data !== mem_word(32'(32'h200 + 4*i))) begin
                failures++; $display("FAIL collide_head i=%0d got=%b/%h/%h exp=1/%h", i, s_iv, s_pc, s_data, 32'(32'h200 + 4*i));
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        repeat (3) tick();
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        redirect_pc = 32'h400;
        tick();
        checks++;
        if (s_iv !== 1'b0 || s_req_valid !== 1'b0) begin
            failures++; $display("FAIL b2b_stall_flush got=%b/%b exp=0/0", s_iv, s_req_valid);
        end
        stall          = 1'b0;
        redirect_valid = 1'b0;
        tick();
        checks++;
        if (s_req_valid !== 1'b1 || s_addr !== 32'h400) begin
            failures++; $display("FAIL b2b_later_wins got=%b/%h exp=1/00000400", s_req_valid, s_addr);
        end
        repeat (1) tick();
        tick();
        checks++;
        if (s_iv !== 1'b1 || s_pc !== 32'h400 || s_pc4 !== 32'h404) begin
            failures++; $display("FAIL b2b_head got=%b/%h/%h exp=1/00000400/00000404", s_iv, s_pc, s_pc4);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++;
        if (s_req_valid !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin
            failures++; $display("FAIL wrap_req_top got=%b/%h exp=1/fffffffc", s_req_valid, s_addr);
        end
        tick();
        checks++;
        if (s_req_valid !== 1'b1 || s_addr !== 32'h0) begin
            failures++; $display("FAIL wrap_req_zero got=%b/%h exp=1/00000000", s_req_valid, s_addr);
        end
        tick();
        checks++;
        if (s_iv !== 1'b1 || s_pc !== 32'hFFFF_FFFC || s_pc4 !== 32'h0 || s_data !== mem_word(32'hFFFF_FFFC)) begin
            failures++; $display("FAIL wrap_head_top got=%b/%h/%h/%h exp=1/fffffffc/00000000/%h", s_iv, s_pc, s_pc4, s_data,
                                 mem_word(32'hFFFF_FFFC));
        end
        tick();
        checks++;
        if (s_iv !== 1'b1 || s_pc !== 32'h0 || s_pc4 !== 32'h4) begin
            failures++; $display("FAIL wrap_head_zero got=%b/%h/%h exp=1/00000000/00000004", s_iv, s_pc, s_pc4);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        lat = 2;
        repeat (4) tick();
        checks++;
        if (s_iv !== 1'b1 || s_pc !== 32'h0) begin failures++; $display("FAIL midrst_setup got=%b/%h exp=1/00000000", s_iv, s_pc); end
        rst = 1'b1;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0 || inst_pc4 !== 32'h0) begin
            failures++; $display("FAIL midrst_outputs got=%b/%b/%h/%h/%h exp=0/0/0/0/0", imem_req_valid, inst_valid, inst_data, inst_pc, inst_pc4);
        end
        do_reset();
        tick();
        checks++;
        if (s_req_valid !== 1'b1 || s_addr !== 32'h0) begin
            failures++; $display("FAIL midrst_restart got=%b/%h exp=1/00000000", s_req_valid, s_addr);
        end
        tick();
        tick();
        checks++;
        if (s_iv !== 1'b1 || s_pc !== 32'h0 || s_data !== mem_word(32'h0)) begin
            failures++; $display("FAIL midrst_head got=%b/%h/%h exp=1/00000000/%h", s_iv, s_pc, s_data, mem_word(32'h0));
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drop();
        test_redirect_collide();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
